// File: rtl/noc_port_arbiter.sv
// Round-robin, burst-limited arbiter: three single-flit valid/ready requesters
// share one registered output stage. An owner keeps the link for at most
// MaxBurst consecutive flits, then the scan rotates past it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no flit accepted in the last load slot; no owner, o_grant = 0
// BURST | a flit was accepted in the last load slot; last_owner holds it
module noc_port_arbiter #(
    parameter int DataWidth = 36,
    parameter int MaxBurst  = 4,
    parameter int CntWidth  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DataWidth-1:0] i_data0,
    input  logic [DataWidth-1:0] i_data1,
    input  logic [DataWidth-1:0] i_data2,
    input  logic                 i_data_valid0,
    input  logic                 i_data_valid1,
    input  logic                 i_data_valid2,
    output logic                 o_data_ready0,
    output logic                 o_data_ready1,
    output logic                 o_data_ready2,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic [2:0]           o_grant,
    output logic                 o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxBurst);

    state_t                state, state_next;
    logic [CntWidth-1:0]   burst_cnt, burst_cnt_next;
    logic [1:0]            last_owner, last_owner_next;
    logic [DataWidth-1:0]  data_next;
    logic                  data_valid_next;
    logic [2:0]            grant_next;
    logic                  busy_next;

    logic [2:0]            valid_vec;
    logic                  any_valid;
    logic                  load;
    logic                  owner_ok;
    logic [1:0]            scan1, scan2;
    logic [1:0]            sel;
    logic [DataWidth-1:0]  sel_data;
    logic [2:0]            sel_onehot;

    assign valid_vec = {i_data_valid2, i_data_valid1, i_data_valid0};
    assign any_valid = |valid_vec;
    assign load      = !o_data_valid || i_data_ready;
    assign owner_ok  = (state == BURST) && valid_vec[last_owner] && (burst_cnt < MAX_CNT);

    // Rotation order after the previous owner; the owner itself is checked last.
    always_comb begin
        scan1 = 2'd0;
        scan2 = 2'd1;
        case (last_owner)
            2'd0:    begin scan1 = 2'd1; scan2 = 2'd2; end
            2'd1:    begin scan1 = 2'd2; scan2 = 2'd0; end
            default: begin scan1 = 2'd0; scan2 = 2'd1; end
        endcase
    end

    // Pick the requester served in this slot and steer its flit.
    always_comb begin
        sel = last_owner;
        if (owner_ok)
            sel = last_owner;
        else if (valid_vec[scan1])
            sel = scan1;
        else if (valid_vec[scan2])
            sel = scan2;
        else
            sel = last_owner;

        case (sel)
            2'd0:    sel_data = i_data0;
            2'd1:    sel_data = i_data1;
            default: sel_data = i_data2;
        endcase

        case (sel)
            2'd0:    sel_onehot = 3'b001;
            2'd1:    sel_onehot = 3'b010;
            default: sel_onehot = 3'b100;
        endcase
    end

    // Readies only for the selected requester, and only when the stage can load.
    always_comb begin
        o_data_ready0 = load && any_valid && (sel == 2'd0);
        o_data_ready1 = load && any_valid && (sel == 2'd1);
        o_data_ready2 = load && any_valid && (sel == 2'd2);
    end

    // Next-state and next-output decode; everything holds unless the stage loads.
    always_comb begin
        state_next      = state;
        burst_cnt_next  = burst_cnt;
        last_owner_next = last_owner;
        data_next       = o_data;
        data_valid_next = o_data_valid;
        grant_next      = o_grant;
        busy_next       = o_busy;

        if (load) begin
            if (any_valid) begin
                state_next      = BURST;
                busy_next       = 1'b1;
                data_next       = sel_data;
                data_valid_next = 1'b1;
                grant_next      = sel_onehot;
                if (owner_ok) begin
                    burst_cnt_next = burst_cnt + CntWidth'(1);
                end else begin
                    // New burst, including a re-grant of an expired owner.
                    burst_cnt_next  = CntWidth'(1);
                    last_owner_next = sel;
                end
            end else begin
                state_next      = IDLE;
                busy_next       = 1'b0;
                data_valid_next = 1'b0;
                grant_next      = 3'b000;
                burst_cnt_next  = '0;
            end
        end
    end

    // State, counters and output stage; reset discards any held flit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            last_owner   <= 2'd2;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_grant      <= 3'b000;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_next;
            burst_cnt    <= burst_cnt_next;
            last_owner   <= last_owner_next;
            o_data       <= data_next;
            o_data_valid <= data_valid_next;
            o_grant      <= grant_next;
            o_busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: two instances (MaxBurst=4 and MaxBurst=1) share
// the same stimulus and are compared each cycle against a behavioural model.
module tb_noc_port_arbiter;

    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din [3];
    logic [2:0]    vin = 3'b000;
    logic          dready = 1'b0;

    logic [1:0][2:0]    rdy;
    logic [1:0][DW-1:0] od;
    logic [1:0]         ov;
    logic [1:0][2:0]    gnt;
    logic [1:0]         busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance.
    int            mb      [2] = '{4, 1};
    bit            m_busy  [2];
    int            m_owner [2];
    int            m_cnt   [2];
    bit            m_ov    [2];
    logic [DW-1:0] m_od    [2];
    logic [2:0]    m_gnt   [2];

    bit            n_busy  [2];
    int            n_owner [2];
    int            n_cnt   [2];
    bit            n_ov    [2];
    logic [DW-1:0] n_od    [2];
    logic [2:0]    n_gnt   [2];

    always #5 clk = ~clk;

    noc_port_arbiter #(.DataWidth(DW), .MaxBurst(4), .CntWidth(3)) dut_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]),
        .i_data_valid0(vin[0]), .i_data_valid1(vin[1]), .i_data_valid2(vin[2]),
        .o_data_ready0(rdy[0][0]), .o_data_ready1(rdy[0][1]), .o_data_ready2(rdy[0][2]),
        .o_data(od[0]), .o_data_valid(ov[0]), .i_data_ready(dready),
        .o_grant(gnt[0]), .o_busy(busy[0])
    );

    noc_port_arbiter #(.DataWidth(DW), .MaxBurst(1), .CntWidth(3)) dut_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]),
        .i_data_valid0(vin[0]), .i_data_valid1(vin[1]), .i_data_valid2(vin[2]),
        .o_data_ready0(rdy[1][0]), .o_data_ready1(rdy[1][1]), .o_data_ready2(rdy[1][2]),
        .o_data(od[1]), .o_data_valid(ov[1]), .i_data_ready(dready),
        .o_grant(gnt[1]), .o_busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_owner[i] = 2; m_cnt[i] = 0;
            m_ov[i] = 0; m_od[i] = '0; m_gnt[i] = 3'b000;
        end
    endtask

    // One cycle: drive inputs, check at negedge, advance the model past posedge.
    task automatic step(input logic [2:0] v, input logic dr);
        logic [63:0] r;
        bit          load, any, keep;
        int          pick;
        logic [2:0]  exp_rdy;
        logic [2:0]  cnt_obs;
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom()};
            din[k] = r[DW-1:0];
        end
        vin = v;
        dready = dr;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            load = !m_ov[i] || dr;
            any  = (v != 3'b000);
            keep = m_busy[i] && v[m_owner[i]] && (m_cnt[i] < mb[i]);
            pick = -1;
            if (keep) pick = m_owner[i];
            else
                for (int s = 1; s <= 3; s++)
                    if (pick < 0 && v[(m_owner[i] + s) % 3]) pick = (m_owner[i] + s) % 3;
            exp_rdy = (load && any) ? (3'b001 << pick) : 3'b000;
            cnt_obs = (i == 0) ? dut_a.burst_cnt : dut_b.burst_cnt;

            check($sformatf("ready%0d", i), 64'(rdy[i]), 64'(exp_rdy));
            check($sformatf("ovalid%0d", i), 64'(ov[i]), 64'(m_ov[i]));
            check($sformatf("odata%0d", i), 64'(od[i]), 64'(m_od[i]));
            check($sformatf("grant%0d", i), 64'(gnt[i]), 64'(m_gnt[i]));
            check($sformatf("busy%0d", i), 64'(busy[i]), 64'(m_busy[i]));
            check($sformatf("cnt%0d", i), 64'(cnt_obs), 64'(m_cnt[i]));

            n_busy[i] = m_busy[i]; n_owner[i] = m_owner[i]; n_cnt[i] = m_cnt[i];
            n_ov[i] = m_ov[i]; n_od[i] = m_od[i]; n_gnt[i] = m_gnt[i];
            if (load && any) begin
                n_od[i] = din[pick]; n_ov[i] = 1; n_busy[i] = 1;
                n_gnt[i] = 3'b001 << pick;
                if (keep) n_cnt[i] = m_cnt[i] + 1;
                else begin n_cnt[i] = 1; n_owner[i] = pick; end
            end else if (load) begin
                n_ov[i] = 0; n_busy[i] = 0; n_cnt[i] = 0; n_gnt[i] = 3'b000;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = n_busy[i]; m_owner[i] = n_owner[i]; m_cnt[i] = n_cnt[i];
            m_ov[i] = n_ov[i]; m_od[i] = n_od[i]; m_gnt[i] = n_gnt[i];
        end
    endtask

    initial begin
        din[0] = '0; din[1] = '0; din[2] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ovalid", 64'(ov[i]), 64'(0));
            check("rst_grant", 64'(gnt[i]), 64'(0));
            check("rst_odata", 64'(od[i]), 64'(0));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle after release: no readies.
        repeat (2) step(3'b000, 1'b1);
        // Single requester streaming, burst wraps with re-grant.
        repeat (6) step(3'b001, 1'b1);
        repeat (2) step(3'b000, 1'b1);
        // All requesters contending.
        repeat (13) step(3'b111, 1'b1);
        // Backpressure with a full output stage.
        repeat (3) step(3'b111, 1'b0);
        repeat (4) step(3'b111, 1'b1);
        repeat (2) step(3'b000, 1'b1);
        // Owner drops valid mid-burst, then returns.
        repeat (2) step(3'b001, 1'b1);
        repeat (3) step(3'b110, 1'b1);
        repeat (8) step(3'b111, 1'b1);

        // Asynchronous reset mid-cycle while the stage holds a flit.
        step(3'b111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("arst_ovalid", 64'(ov[i]), 64'(0));
            check("arst_grant", 64'(gnt[i]), 64'(0));
            check("arst_busy", 64'(busy[i]), 64'(0));
        end
        vin = 3'b000;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) step(3'b000, 1'b1);

        // Randomized traffic and backpressure.
        for (int n = 0; n < 2000; n++)
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Round-robin, burst-limited arbiter that shares one switch output link among three requesting input links of the hierarchical NoC.
- Sits in front of a switch output port, or in front of a shared up-link between tree levels.
- Each requester offers single-flit packets on a valid/ready handshake. The block picks one requester per accept slot and registers the chosen flit into a one-entry output stage that runs at full throughput.
- Burst limiting bounds how long one requester holds the link; round-robin rotation prevents starvation.

Parameters:
- DataWidth, 36, flit width including the address field.
- MaxBurst, 4, maximum consecutive flits granted to one owner before re-arbitration; legal range 1..(2^CntWidth)-1.
- CntWidth, 3, width of the burst counter.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_data0 / i_data1 / i_data2  in  DataWidth  requester flits.
- i_data_valid0 / i_data_valid1 / i_data_valid2  in  1  requester valid.
- o_data_ready0 / o_data_ready1 / o_data_ready2  out  1  requester ready; combinational.
- o_data  out  DataWidth  registered output flit.
- o_data_valid  out  1  registered output valid.
- i_data_ready  in  1  downstream ready.
- o_grant  out  3  one-hot current owner; 0 when IDLE; registered.
- o_busy  out  1  high in state BURST; registered.

Behaviour:
- Reset (async, i_reset=0):
  - o_data=0, o_data_valid=0, o_grant=0, o_busy=0.
  - state=IDLE, burst_cnt=0, last_owner=2, so the first scan starts at requester 0.
  - A flit held in the output stage is discarded.
  - Release is synchronous to i_clk.
- Slot availability: load = !o_data_valid || i_data_ready. An output-stage flit transfers downstream when o_data_valid && i_data_ready.
- Owner continuation: owner_ok = (state==BURST) && i_data_valid[last_owner] && (burst_cnt < MaxBurst).
- Selection (combinational):
  - If owner_ok, sel = last_owner.
  - Otherwise sel = the first requester with valid=1, scanning (last_owner+1) mod 3, (last_owner+2) mod 3, last_owner.
  - The owner can be re-selected only after the other two have been checked.
- o_data_ready_k = load && any_valid && (sel==k).
  - Ready may depend on the valid inputs of other requesters.
  - A requester must not make its valid depend on its ready.
- Clock edge with load && any_valid:
  - o_data <= i_data[sel]; o_data_valid <= 1; state <= BURST; o_grant <= onehot(sel).
  - If owner_ok, burst_cnt <= burst_cnt+1.
  - Otherwise burst_cnt <= 1 and last_owner <= sel. This includes re-granting the same owner after its burst expires.
- Clock edge with load && !any_valid:
  - o_data_valid <= 0; o_data holds its last value.
  - state <= IDLE; burst_cnt <= 0; o_grant <= 0; last_owner is kept.
- Clock edge with !load: all readies are 0; o_data, o_data_valid, state, burst_cnt, last_owner and o_grant hold.
- Latency and throughput:
  - An accepted flit appears on o_data one cycle after its handshake.
  - One flit per cycle is sustained while i_data_ready=1. There are no bubbles on owner switches.
- Boundary cases:
  - MaxBurst=1 gives pure round-robin.
  - Burst expiry with only the owner valid re-grants the owner with burst_cnt=1 and no idle cycle.
  - Owner dropping valid mid-burst causes an immediate switch in the same slot.
  - Simultaneous downstream pop and new accept is allowed.
  - burst_cnt never exceeds MaxBurst.

Test Plan:
1. Async reset: assert i_reset=0 mid-cycle while o_data_valid=1 -> o_data_valid, o_grant, o_busy drop to 0 immediately. After release, all o_data_ready* stay 0 with no valid inputs.
2. Only requester 0 valid, 6 flits D0..D5, i_data_ready=1, MaxBurst=4 -> accepted on 6 consecutive cycles; o_data shows D0..D5 starting 1 cycle later; burst_cnt runs 1,2,3,4,1,2; o_grant=3'b001 throughout.
3. All three requesters valid continuously, MaxBurst=4 -> accepted sources in the order 0,0,0,0,1,1,1,1,2,2,2,2,0; o_grant tracks the sources.
4. Same stimulus with MaxBurst=1 -> accepted sources in the order 0,1,2,0,1,2.
5. Backpressure: output full and i_data_ready=0 for 3 cycles -> all o_data_ready*=0 and o_data/o_data_valid stable. Raising i_data_ready resumes with no flit lost or duplicated.
6. Requester 0 owns after 2 flits, then drops valid while requesters 1 and 2 are valid -> next accepted flit is from 1 with burst_cnt=1. Requester 0 re-asserting is then served after 1 and 2 per the rotation.
